rst_sequencer: RTL

Synthesizable power-on/software reset sequencer for the lab designs. It takes the board clock and the asynchronous active-low system reset, synchronizes reset release, and stretches it. It then releases up to eight downstream block resets one at a time, waiting for each block's ready handshake before releasing the next. A per-stage timeout drives it into a latched fault state, and a synchronous software reset request restarts the whole sequence.

---
 rtl/rst_sequencer_if.sv | 43 ++++
 rtl/rst_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer_if.sv
// rst_sequencer_if
//   Bundles the sequencer's control inputs and reset/status outputs.
//   The clock and the system reset stay as plain ports on the sequencer.
//
//   SwRst_i       synchronous software reset request (level, sampled each edge)
//   StageRdy_i    per-stage ready handshake from the downstream blocks
//   StageRst_n_o  per-stage active-low reset to the downstream blocks
//   Busy_o        sequence in progress
//   Done_o        every stage released and ready
//   Fault_o       sticky stage-ready timeout
//
//   master: the side that drives requests/ready and observes the resets
//   slave : the sequencer itself
`timescale 1ns/1ps

interface rst_sequencer_if #(
    parameter int N_STAGES = 3
);
    logic                SwRst_i;
    logic [N_STAGES-1:0] StageRdy_i;
    logic [N_STAGES-1:0] StageRst_n_o;
    logic                Busy_o;
    logic                Done_o;
    logic                Fault_o;

    modport master (
        output SwRst_i,
        output StageRdy_i,
        input  StageRst_n_o,
        input  Busy_o,
        input  Done_o,
        input  Fault_o
    );

    modport slave (
        input  SwRst_i,
        input  StageRdy_i,
        output StageRst_n_o,
        output Busy_o,
        output Done_o,
        output Fault_o
    );
endinterface

// File: rtl/rst_sequencer.sv
// rst_sequencer
//   Power-on / software reset sequencer. Synchronizes release of the
//   asynchronous system reset, holds every stage reset for STRETCH cycles,
//   then releases the stage resets one at a time. Each stage must show
//   ready within TIMEOUT cycles of its release; a ready stage is followed by
//   STAGE_GAP cycles before the next one is released. A missed ready drops
//   every stage back into reset and latches Fault_o until a software reset
//   or a system reset.
//
//   Ports
//     Clk    system clock, rising edge
//     Rst_n  asynchronous active-low reset (release synchronized internally)
//     bus    rst_sequencer_if.slave: SwRst_i, StageRdy_i in;
//            StageRst_n_o, Busy_o, Done_o, Fault_o out (all registered)
`timescale 1ns/1ps

module rst_sequencer #(
    parameter int N_STAGES    = 3,
    parameter int STRETCH     = 16,
    parameter int STAGE_GAP   = 4,
    parameter int TIMEOUT     = 32,
    parameter int SYNC_STAGES = 2
) (
    input logic             Clk,
    input logic             Rst_n,
    rst_sequencer_if.slave  bus
);

    localparam int MAX_SG  = (STRETCH > STAGE_GAP) ? STRETCH : STAGE_GAP;
    localparam int MAX_CNT = (MAX_SG > TIMEOUT) ? MAX_SG : TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    // The counter value seen on the edge that completes each interval.
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_STAGES - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [N_STAGES-1:0]  stage_rst_n_q, stage_rst_n_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 fault_q, fault_d;

    logic                 rel_fire;
    logic [IDX_W-1:0]     rel_idx;

    always_comb begin
        // Release chain: shifts ones in once Rst_n is high; the top bit is
        // the synchronized "reset released" qualifier for the FSM.
        sync_d        = {sync_q[SYNC_STAGES-2:0], 1'b1};
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        stage_rst_n_d = stage_rst_n_q;
        rel_fire      = 1'b0;
        rel_idx       = '0;

        if (bus.SwRst_i) begin
            state_d       = S_HOLD;
            cnt_d         = '0;
            idx_d         = '0;
            stage_rst_n_d = '0;
        end else if (sync_q[SYNC_STAGES-1]) begin
            case (state_q)
                S_HOLD: begin
                    if (cnt_q == STRETCH_LAST) begin
                        rel_fire = 1'b1;
                        rel_idx  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    // Ready wins over a timeout landing on the same edge.
                    if (bus.StageRdy_i[idx_q]) begin
                        state_d = (idx_q == LAST_IDX) ? S_DONE : S_GAP;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d       = S_FAULT;
                        cnt_d         = '0;
                        stage_rst_n_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        rel_fire = 1'b1;
                        rel_idx  = idx_q + IDX_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE, S_FAULT: begin
                    // Terminal until SwRst_i or Rst_n.
                end
                default: begin
                    state_d       = S_HOLD;
                    cnt_d         = '0;
                    idx_d         = '0;
                    stage_rst_n_d = '0;
                end
            endcase

            // A stage's ready is already observed on its own release edge,
            // so a block that is ready immediately skips the WAIT state.
            if (rel_fire) begin
                stage_rst_n_d = stage_rst_n_q | (N_STAGES'(1) << rel_idx);
                idx_d         = rel_idx;
                cnt_d         = '0;
                if (bus.StageRdy_i[rel_idx]) begin
                    state_d = (rel_idx == LAST_IDX) ? S_DONE : S_GAP;
                end else begin
                    state_d = S_WAIT;
                end
            end
        end

        // Status is decoded from the next state so the flags are registered
        // and exactly one of them is ever set.
        busy_d  = (state_d == S_HOLD) || (state_d == S_WAIT) || (state_d == S_GAP);
        done_d  = (state_d == S_DONE);
        fault_d = (state_d == S_FAULT);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= S_HOLD;
            cnt_q         <= '0;
            idx_q         <= '0;
            sync_q        <= '0;
            stage_rst_n_q <= '0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            sync_q        <= sync_d;
            stage_rst_n_q <= stage_rst_n_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.StageRst_n_o = stage_rst_n_q;
    assign bus.Busy_o       = busy_q;
    assign bus.Done_o       = done_q;
    assign bus.Fault_o      = fault_q;

endmodule
